// File: rtl/matraptor_pkg.sv
// Shared types and helpers for the MatRaptor row pipeline.
//   entry_t       : one sparse (val, col) element, shared with the phase-1 PE.
//   merge_state_t : control states of the phase-2 queue merger.
//   clog2         : constant-foldable ceiling log2 (clog2(1) == 0).
package matraptor_pkg;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_IDX_W  = 16;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] val;
    logic [ENTRY_IDX_W-1:0]  col;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MERGE,
    S_DRAIN,
    S_WAIT
  } merge_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/merge_min_tree.sv
// Combinational minimum-column finder over NQ lanes.
// A balanced compare tree, clog2(NQ) levels deep, reduces the live lane
// columns to their minimum; the lower lane index wins ties when routing.
// Every live lane whose column equals the minimum is flagged in hit.
//   live    : lanes taking part in the comparison
//   cols    : per-lane columns, lane i at [i*IDX_W +: IDX_W]
//   min_col : smallest column among live lanes (don't-care when live == 0)
//   hit     : live lanes whose column equals min_col
module merge_min_tree
  import matraptor_pkg::*;
#(
  parameter int NQ    = 8,
  parameter int IDX_W = 16
) (
  input  logic [NQ-1:0]       live,
  input  logic [NQ*IDX_W-1:0] cols,
  output logic [IDX_W-1:0]    min_col,
  output logic [NQ-1:0]       hit
);

  localparam int LV = clog2(NQ);
  localparam int P  = 1 << LV;

  // Level 0 holds the (padded) leaves; level LV holds the root.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [W-1:0]       v;
    logic [W*IDX_W-1:0] c;

    for (genvar j = 0; j < W; j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < NQ) begin : g_real
          assign v[j]                  = live[j];
          assign c[j*IDX_W +: IDX_W]   = cols[j*IDX_W +: IDX_W];
        end else begin : g_pad
          assign v[j]                  = 1'b0;
          assign c[j*IDX_W +: IDX_W]   = '0;
        end
      end else begin : g_cmp
        logic             lv, rv, take_left;
        logic [IDX_W-1:0] lc, rc;
        assign lv = g_lvl[l-1].v[2*j];
        assign rv = g_lvl[l-1].v[2*j+1];
        assign lc = g_lvl[l-1].c[(2*j)*IDX_W +: IDX_W];
        assign rc = g_lvl[l-1].c[(2*j+1)*IDX_W +: IDX_W];
        // Left subtree covers the lower lane indices, so '<=' resolves ties to it.
        assign take_left             = lv && (!rv || (lc <= rc));
        assign v[j]                  = lv || rv;
        assign c[j*IDX_W +: IDX_W]   = take_left ? lc : rc;
      end
    end
  end

  assign min_col = g_lvl[LV].c[IDX_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit = '0;
    for (int i = 0; i < NQ; i++) begin
      hit[i] = live[i] && (cols[i*IDX_W +: IDX_W] == min_col);
    end
  end

endmodule

// File: rtl/p2_queue_merger.sv
// Phase-2 queue merger: NQ-way merge by column of the column-sorted partial
// product vectors of one output row, summing entries with equal columns, and
// emitting one sorted duplicate-free (col, val) stream per row.
//   row_valid/row_ready/row_id/row_mask : row descriptor handshake
//   q_valid/q_ready/q_val/q_col/q_last  : per-lane head of each input queue
//   out_valid/out_ready/out_val/out_row/out_col/out_last : merged output beat
//   row_done/row_nnz                    : completion pulse and beat count
// Pipeline: min tree -> hold register (accumulates equal columns) -> output
// register. A column leaves hold only once a larger column arrives or the
// row ends, so the output never repeats a column.
module p2_queue_merger
  import matraptor_pkg::*;
#(
  parameter int DATA_W = ENTRY_DATA_W,
  parameter int IDX_W  = ENTRY_IDX_W,
  parameter int NQ     = 8,
  parameter int CNT_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [IDX_W-1:0]     row_id,
  input  logic [NQ-1:0]        row_mask,
  input  logic [NQ-1:0]        q_valid,
  output logic [NQ-1:0]        q_ready,
  input  logic [NQ*DATA_W-1:0] q_val,
  input  logic [NQ*IDX_W-1:0]  q_col,
  input  logic [NQ-1:0]        q_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_val,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 row_done,
  output logic [CNT_W-1:0]     row_nnz
);

  merge_state_t state, state_nx;

  logic              ready_en;   // low only while in reset, so row_ready stays 0 then
  logic [IDX_W-1:0]  row_id_q;
  logic [NQ-1:0]     live;
  logic              hold_vld;
  logic [IDX_W-1:0]  hold_col;
  logic [DATA_W-1:0] hold_val;
  logic [CNT_W-1:0]  cnt;

  logic [IDX_W-1:0]  min_col;
  logic [NQ-1:0]     hit;
  logic [DATA_W-1:0] sum;
  logic [NQ-1:0]     live_after;
  logic              all_valid, out_free, hold_same, can_adv, step, accept;

  merge_min_tree #(.NQ(NQ), .IDX_W(IDX_W)) u_min_tree (
    .live    (live),
    .cols    (q_col),
    .min_col (min_col),
    .hit     (hit)
  );

  assign row_ready  = ready_en && (state == S_IDLE);
  assign accept     = row_valid && row_ready;
  assign all_valid  = &(q_valid | ~live);
  assign out_free   = !out_valid || out_ready;
  assign hold_same  = hold_vld && (hold_col == min_col);
  // Hold can take a new min if it is empty, merges into it, or can spill into out.
  assign can_adv    = !hold_vld || hold_same || out_free;
  assign step       = (state == S_MERGE) && all_valid && can_adv;
  assign q_ready    = step ? hit : '0;
  assign live_after = live & ~(hit & q_last);
  assign out_row    = row_id_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NQ; i++) begin
      if (hit[i]) sum = sum + q_val[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept && (row_mask != '0)) state_nx = S_MERGE;
      S_MERGE: if (step && (live_after == '0)) state_nx = S_DRAIN;
      S_DRAIN: if (out_free)                   state_nx = S_WAIT;
      S_WAIT:  if (out_valid && out_ready)     state_nx = S_IDLE;
      default:                                 state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      row_id_q  <= '0;
      live      <= '0;
      hold_vld  <= 1'b0;
      hold_col  <= '0;
      hold_val  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      row_done  <= 1'b0;
      row_nnz   <= '0;
    end else begin
      ready_en <= 1'b1;
      row_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;  // a load below overrides this

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            row_id_q <= row_id;
            live     <= row_mask;
            cnt      <= '0;
            hold_vld <= 1'b0;
            if (row_mask == '0) begin
              row_done <= 1'b1;
              row_nnz  <= '0;
            end
          end
        end
        S_MERGE: begin
          if (step) begin
            live <= live_after;
            if (hold_same) begin
              hold_val <= hold_val + sum;
            end else begin
              if (hold_vld) begin
                out_valid <= 1'b1;
                out_col   <= hold_col;
                out_val   <= hold_val;
                out_last  <= 1'b0;
                cnt       <= cnt + CNT_W'(1);
              end
              hold_vld <= 1'b1;
              hold_col <= min_col;
              hold_val <= sum;
            end
          end
        end
        S_DRAIN: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_col   <= hold_col;
            out_val   <= hold_val;
            out_last  <= 1'b1;
            cnt       <= cnt + CNT_W'(1);
            hold_vld  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (out_valid && out_ready) begin
            out_last <= 1'b0;
            row_done <= 1'b1;
            row_nnz  <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_p2_queue_merger.sv
// Self-checking bench for p2_queue_merger. Lane contents live in per-lane
// queues; the expected row is the set of distinct columns over all
// participating lanes, ascending, each with the wrapped sum of its values.
module tb_p2_queue_merger;

  localparam int NQ = 8;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int CW = 24;

  typedef struct {
    int unsigned col;
    logic [31:0] val;
  } ent_t;

  logic             clk, rst_n;
  logic             row_valid, row_ready;
  logic [IW-1:0]    row_id;
  logic [NQ-1:0]    row_mask;
  logic [NQ-1:0]    q_valid, q_ready, q_last;
  logic [NQ*DW-1:0] q_val;
  logic [NQ*IW-1:0] q_col;
  logic             out_valid, out_ready, out_last, row_done;
  logic [DW-1:0]    out_val;
  logic [IW-1:0]    out_row, out_col;
  logic [CW-1:0]    row_nnz;

  int checks = 0;
  int failures = 0;

  ent_t lq [NQ][$];

  p2_queue_merger dut (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_ready(row_ready), .row_id(row_id), .row_mask(row_mask),
    .q_valid(q_valid), .q_ready(q_ready), .q_val(q_val), .q_col(q_col), .q_last(q_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .row_done(row_done), .row_nnz(row_nnz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input int unsigned col, input logic [31:0] val);
    ent_t e;
    e.col = col;
    e.val = val;
    lq[lane].push_back(e);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NQ; i++) lq[i].delete();
  endtask

  // Lanes 0/1 of the reference two-lane row.
  task automatic load_two_lane();
    clear_lanes();
    push(0, 1, 10); push(0, 4, 20); push(0, 7, 30);
    push(1, 2, 1);  push(1, 4, 2);  push(1, 9, 3);
  endtask

  // oready_mode: 0 = always ready, 1 = toggle each cycle, 2 = random.
  // stall_lane drops that lane's q_valid for cycles 3..6; max_beats>0 aborts early.
  task automatic run_row(input logic [IW-1:0] rid, input logic [NQ-1:0] mask,
                         input int stall_lane, input int oready_mode,
                         input bit rnd_stall, input int max_beats);
    logic [31:0]  acc [int unsigned];
    int unsigned  k;
    ent_t         exp_q [$];
    ent_t         e;
    int           exp_n, beats;
    bit           done, aborted, prev_stall, stall;
    logic [63:0]  prev_snap;
    logic [NQ-1:0] live_tb;

    for (int i = 0; i < NQ; i++) begin
      if (mask[i]) begin
        foreach (lq[i][j]) begin
          if (acc.exists(lq[i][j].col)) acc[lq[i][j].col] = acc[lq[i][j].col] + lq[i][j].val;
          else                          acc[lq[i][j].col] = lq[i][j].val;
        end
      end
    end
    if (acc.first(k)) begin
      do begin
        e.col = k;
        e.val = acc[k];
        exp_q.push_back(e);
      end while (acc.next(k));
    end
    exp_n = exp_q.size();

    @(negedge clk);
    row_valid = 1'b1; row_id = rid; row_mask = mask;
    q_valid = '0; out_ready = 1'b1;
    #1;
    check("row_ready_idle", {63'd0, row_ready}, 64'd1);
    check("row_done_is_pulse", {63'd0, row_done}, 64'd0);
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    row_valid = 1'b0;

    done = 0; aborted = 0; beats = 0; prev_stall = 0; prev_snap = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < NQ; i++) begin
        live_tb[i] = mask[i] && (lq[i].size() > 0);
        stall = ((i == stall_lane) && (cyc >= 3) && (cyc < 7)) ||
                (rnd_stall && ($urandom_range(3) == 0));
        if (lq[i].size() > 0) begin
          q_col[i*IW +: IW] = lq[i][0].col[IW-1:0];
          q_val[i*DW +: DW] = lq[i][0].val;
          q_last[i]         = (lq[i].size() == 1);
          q_valid[i]        = mask[i] && !stall;
        end else begin
          q_valid[i] = 1'b0;
          q_last[i]  = 1'b0;
        end
      end
      case (oready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(1) == 1);
      endcase
      #1;

      check("q_ready_only_live_valid", {56'd0, q_ready & ~(q_valid & live_tb)}, 64'd0);
      if ((live_tb & ~q_valid) != '0) check("stall_no_pop", {56'd0, q_ready}, 64'd0);
      for (int i = 0; i < NQ; i++) begin
        if (q_ready[i] && lq[i].size() > 0) void'(lq[i].pop_front());
      end

      if (prev_stall)
        check("out_stable_while_stalled", {13'd0, out_valid, out_last, out_col, out_val}, prev_snap);
      prev_stall = out_valid && !out_ready;
      prev_snap  = {13'd0, out_valid, out_last, out_col, out_val};

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_col", {48'd0, out_col}, {32'd0, e.col});
          check("beat_val", {32'd0, out_val}, {32'd0, e.val});
          check("beat_row", {48'd0, out_row}, {48'd0, rid});
          check("beat_last", {63'd0, out_last}, {63'd0, exp_q.size() == 0});
        end
        beats++;
      end

      if (row_done) begin
        check("row_nnz", {40'd0, row_nnz}, 64'(exp_n));
        check("row_all_beats_seen", 64'(exp_q.size()), 64'd0);
        done = 1;
        break;
      end
      if (max_beats > 0 && beats >= max_beats) begin
        aborted = 1;
        break;
      end
    end
    if (!done && !aborted) check("row_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    int unsigned c;
    logic [NQ-1:0] m;

    rst_n = 1'b0; row_valid = 1'b0; row_id = '0; row_mask = '0;
    q_valid = '0; q_val = '0; q_col = '0; q_last = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_row_ready", {63'd0, row_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_row_done", {63'd0, row_done}, 64'd0);
    check("rst_row_nnz", {40'd0, row_nnz}, 64'd0);
    check("rst_q_ready", {56'd0, q_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_row_ready", {63'd0, row_ready}, 64'd1);

    // Two-lane reference row.
    load_two_lane();
    run_row(16'd3, 8'b0000_0011, -1, 0, 0, 0);

    // Empty row.
    clear_lanes();
    run_row(16'd5, 8'b0000_0000, -1, 0, 0, 0);

    // Single lane with in-lane duplicate columns.
    clear_lanes();
    push(3, 6, 1); push(3, 6, 2); push(3, 8, 3);
    run_row(16'd7, 8'b0000_1000, -1, 0, 0, 0);

    // Wrap-around on an equal column.
    clear_lanes();
    push(3, 5, 32'hFFFF_FFFF); push(3, 5, 32'd2);
    run_row(16'd8, 8'b0000_1000, -1, 0, 0, 0);

    // Lane 1 valid held low for 4 cycles mid-row.
    load_two_lane();
    run_row(16'd3, 8'b0000_0011, 1, 0, 0, 0);

    // Downstream backpressure toggling each cycle.
    load_two_lane();
    run_row(16'd3, 8'b0000_0011, -1, 1, 0, 0);

    // Reset after the second beat.
    load_two_lane();
    run_row(16'd9, 8'b0000_0011, -1, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrow_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrow_rst_q_ready", {56'd0, q_ready}, 64'd0);
    check("midrow_rst_row_ready", {63'd0, row_ready}, 64'd0);
    check("midrow_rst_row_done", {63'd0, row_done}, 64'd0);
    clear_lanes();
    q_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrow_post_rst_row_ready", {63'd0, row_ready}, 64'd1);
    load_two_lane();
    run_row(16'd10, 8'b0000_0011, -1, 0, 0, 0);

    // Randomized rows: random masks, lengths, columns, stalls, backpressure.
    for (int r = 0; r < 25; r++) begin
      clear_lanes();
      m = NQ'($urandom_range(255));
      for (int i = 0; i < NQ; i++) begin
        if (m[i]) begin
          n = $urandom_range(5, 1);
          c = $urandom_range(6);
          for (int j = 0; j < n; j++) begin
            push(i, c, $urandom);
            c = c + $urandom_range(3);
          end
        end
      end
      run_row(IW'(100 + r), m, -1, 2, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
